// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared constants for the forwarding/interlock unit: EX operand mux encodings
// and the default register address width.
package hazard_pkg;

    localparam int unsigned REG_AW_DEF = 5;

    typedef logic [1:0] fwd_t;

    localparam fwd_t FWD_REG   = 2'b00;
    localparam fwd_t FWD_EXMEM = 2'b10;
    localparam fwd_t FWD_MEMWB = 2'b01;

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side bundle for hazard_forward_ctrl: ID/EX/MEM/WB register info,
// multi-cycle unit events, and the forward/stall/scoreboard results.
interface hazard_forward_ctrl_if
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW  = REG_AW_DEF,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned CNT_W   = 16
);

    logic                        id_valid;
    logic [NUM_SRC*REG_AW-1:0]   id_rs;
    logic [NUM_SRC-1:0]          id_rs_used;
    logic [REG_AW-1:0]           id_rd;
    logic                        id_rd_used;
    logic [NUM_SRC*REG_AW-1:0]   ex_rs;
    logic [REG_AW-1:0]           ex_rd;
    logic                        ex_memread;
    logic                        ex_regwrite;
    logic [REG_AW-1:0]           exmem_rd;
    logic                        exmem_regwrite;
    logic [REG_AW-1:0]           memwb_rd;
    logic                        memwb_regwrite;
    logic                        mc_issue;
    logic [REG_AW-1:0]           mc_issue_rd;
    logic                        mc_done;
    logic [REG_AW-1:0]           mc_done_rd;
    logic                        flush;

    logic [NUM_SRC*2-1:0]        fwd_sel;
    logic                        stall;
    logic [2**REG_AW-1:0]        busy;
    logic [CNT_W-1:0]            stall_cnt;

    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_rd_used,
        output ex_rs, ex_rd, ex_memread, ex_regwrite,
        output exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite,
        output mc_issue, mc_issue_rd, mc_done, mc_done_rd, flush,
        input  fwd_sel, stall, busy, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rs_used, id_rd, id_rd_used,
        input  ex_rs, ex_rd, ex_memread, ex_regwrite,
        input  exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite,
        input  mc_issue, mc_issue_rd, mc_done, mc_done_rd, flush,
        output fwd_sel, stall, busy, stall_cnt
    );

endinterface

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Forward select for one EX source operand; the newer EX/MEM result beats MEM/WB.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_regwrite,
    output fwd_t              sel
);

    always_comb begin
        sel = FWD_REG;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Operand forwarding and ID interlock for the 5-stage pipeline: load-use,
// multi-cycle RAW/WAW scoreboard, and a saturating stall-cycle counter.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW  = REG_AW_DEF,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_forward_ctrl_if.slave bus
);

    localparam int unsigned NREG = 2**REG_AW;

    logic [NUM_SRC*2-1:0] fwd_sel;
    logic [NREG-1:0]      busy_q;
    logic [NREG-1:0]      busy_nxt;
    logic [CNT_W-1:0]     cnt_q;
    logic                 load_use;
    logic                 raw_mc;
    logic                 waw_mc;
    logic                 stall;
    logic [REG_AW-1:0]    src;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
        fwd_select #(.REG_AW(REG_AW)) u_fwd (
            .rs             (bus.ex_rs[k*REG_AW +: REG_AW]),
            .exmem_rd       (bus.exmem_rd),
            .exmem_regwrite (bus.exmem_regwrite),
            .memwb_rd       (bus.memwb_rd),
            .memwb_regwrite (bus.memwb_regwrite),
            .sel            (fwd_sel[k*2 +: 2])
        );
    end

    // Issue in the same cycle counts as busy so the ID consumer cannot slip past.
    always_comb begin
        load_use = 1'b0;
        raw_mc   = 1'b0;
        src      = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            src = bus.id_rs[k*REG_AW +: REG_AW];
            if (bus.id_rs_used[k]) begin
                if (bus.ex_memread && bus.ex_regwrite && (bus.ex_rd != '0) && (src == bus.ex_rd)) begin
                    load_use = 1'b1;
                end
                if ((src != '0) && (busy_q[src] || (bus.mc_issue && (bus.mc_issue_rd == src)))) begin
                    raw_mc = 1'b1;
                end
            end
        end
        waw_mc = bus.id_rd_used && (bus.id_rd != '0) &&
                 (busy_q[bus.id_rd] || (bus.mc_issue && (bus.mc_issue_rd == bus.id_rd)));
        stall  = bus.id_valid && !bus.flush && (load_use || raw_mc || waw_mc);
    end

    // Clear first, then set, so a same-register issue overrides a completion.
    always_comb begin
        busy_nxt = busy_q;
        if (bus.mc_done) begin
            busy_nxt[bus.mc_done_rd] = 1'b0;
        end
        if (bus.mc_issue && (bus.mc_issue_rd != '0)) begin
            busy_nxt[bus.mc_issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_nxt;
            if (stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.fwd_sel   = fwd_sel;
    assign bus.stall     = stall;
    assign bus.busy      = busy_q;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: stimulus pushes hand-computed
// expectations; a negedge monitor pops and compares them.
module tb_hazard_forward_ctrl;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned CNT_W   = 4;

    typedef struct {
        string       name;
        logic [3:0]  fwd;
        logic        stall;
        logic [31:0] busy;
        logic [3:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   stim_done = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    hazard_forward_ctrl_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) bus ();

    hazard_forward_ctrl #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic clear_in();
        bus.id_valid       = 1'b0;
        bus.id_rs          = '0;
        bus.id_rs_used     = '0;
        bus.id_rd          = '0;
        bus.id_rd_used     = 1'b0;
        bus.ex_rs          = '0;
        bus.ex_rd          = '0;
        bus.ex_memread     = 1'b0;
        bus.ex_regwrite    = 1'b0;
        bus.exmem_rd       = '0;
        bus.exmem_regwrite = 1'b0;
        bus.memwb_rd       = '0;
        bus.memwb_regwrite = 1'b0;
        bus.mc_issue       = 1'b0;
        bus.mc_issue_rd    = '0;
        bus.mc_done        = 1'b0;
        bus.mc_done_rd     = '0;
        bus.flush          = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic expect_out(string n, logic [3:0] f, logic s, logic [31:0] b, logic [3:0] c);
        exp_t e;
        e.name  = n;
        e.fwd   = f;
        e.stall = s;
        e.busy  = b;
        e.cnt   = c;
        q.push_back(e);
    endtask

    // ID instruction reading x9 and writing x4
    task automatic id_x9_x4();
        bus.id_valid   = 1'b1;
        bus.id_rs      = {5'd0, 5'd9};
        bus.id_rs_used = 2'b01;
        bus.id_rd      = 5'd4;
        bus.id_rd_used = 1'b1;
    endtask

    function automatic void chk(string n, string field, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%h expected=%h", n, field, act, exp);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        int   guard;
        guard = 0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "fwd_sel", 32'(bus.fwd_sel), 32'(e.fwd));
                chk(e.name, "stall", 32'(bus.stall), 32'(e.stall));
                chk(e.name, "busy", bus.busy, e.busy);
                chk(e.name, "stall_cnt", 32'(bus.stall_cnt), 32'(e.cnt));
            end else if (stim_done) begin
                break;
            end
            guard++;
            if (guard > 2000) begin
                errors++;
                $display("FAIL timeout actual=%0d expected<=2000 cycles", guard);
                break;
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : stimulus
        clear_in();
        next_cycle();
        expect_out("reset", 4'b0000, 1'b0, 32'h0, 4'd0);
        next_cycle();
        rst_n = 1'b1;
        expect_out("idle", 4'b0000, 1'b0, 32'h0, 4'd0);

        next_cycle();
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd5;
        bus.ex_rs = {5'd5, 5'd5};
        expect_out("fwd_exmem_both", 4'b1010, 1'b0, 32'h0, 4'd0);
        next_cycle();
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd5;
        bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd5;
        bus.ex_rs = {5'd5, 5'd5};
        expect_out("fwd_exmem_prio", 4'b1010, 1'b0, 32'h0, 4'd0);
        next_cycle();
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd0;
        bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd7;
        bus.ex_rs = {5'd7, 5'd0};
        expect_out("fwd_x0_memwb", 4'b0100, 1'b0, 32'h0, 4'd0);
        next_cycle();
        bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd3;
        bus.ex_rs = {5'd4, 5'd3};
        expect_out("fwd_memwb_src0", 4'b0001, 1'b0, 32'h0, 4'd0);

        next_cycle();
        bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd3;
        bus.id_valid = 1'b1; bus.id_rs = {5'd3, 5'd1}; bus.id_rs_used = 2'b10;
        expect_out("load_use", 4'b0000, 1'b1, 32'h0, 4'd0);
        next_cycle();
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd3;
        bus.id_valid = 1'b1; bus.id_rs = {5'd3, 5'd1}; bus.id_rs_used = 2'b10;
        expect_out("load_use_release", 4'b0000, 1'b0, 32'h0, 4'd1);
        next_cycle();
        bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd3;
        bus.id_valid = 1'b1; bus.id_rs = {5'd3, 5'd1}; bus.id_rs_used = 2'b01;
        expect_out("load_use_unused_src", 4'b0000, 1'b0, 32'h0, 4'd1);

        next_cycle();
        bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd9;
        bus.id_valid = 1'b1; bus.id_rs = {5'd0, 5'd9}; bus.id_rs_used = 2'b01;
        expect_out("mc_raw_issue", 4'b0000, 1'b1, 32'h0, 4'd1);
        next_cycle();
        bus.id_valid = 1'b1; bus.id_rs = {5'd0, 5'd9}; bus.id_rs_used = 2'b01;
        expect_out("mc_raw_busy", 4'b0000, 1'b1, 32'h200, 4'd2);
        next_cycle();
        bus.mc_done = 1'b1; bus.mc_done_rd = 5'd9;
        bus.id_valid = 1'b1; bus.id_rs = {5'd0, 5'd9}; bus.id_rs_used = 2'b01;
        expect_out("mc_raw_done", 4'b0000, 1'b1, 32'h200, 4'd3);
        next_cycle();
        bus.id_valid = 1'b1; bus.id_rs = {5'd0, 5'd9}; bus.id_rs_used = 2'b01;
        expect_out("mc_raw_after_done", 4'b0000, 1'b0, 32'h0, 4'd4);

        next_cycle();
        bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd4;
        bus.mc_done  = 1'b1; bus.mc_done_rd  = 5'd4;
        expect_out("set_clear_same", 4'b0000, 1'b0, 32'h0, 4'd4);
        next_cycle();
        bus.id_valid = 1'b1; bus.id_rd = 5'd4; bus.id_rd_used = 1'b1;
        expect_out("waw_stall", 4'b0000, 1'b1, 32'h10, 4'd4);
        next_cycle();
        bus.id_valid = 1'b1; bus.id_rd = 5'd4;
        bus.id_rs = {5'd0, 5'd0}; bus.id_rs_used = 2'b01;
        bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd0;
        expect_out("x0_never_busy", 4'b0000, 1'b0, 32'h10, 4'd5);
        next_cycle();
        bus.mc_done = 1'b1; bus.mc_done_rd = 5'd7;
        expect_out("done_not_busy", 4'b0000, 1'b0, 32'h10, 4'd5);
        next_cycle();
        bus.mc_issue = 1'b1; bus.mc_issue_rd = 5'd9;
        expect_out("reissue_x9", 4'b0000, 1'b0, 32'h10, 4'd5);

        next_cycle();
        id_x9_x4();
        bus.flush = 1'b1;
        expect_out("flush_masks", 4'b0000, 1'b0, 32'h210, 4'd5);
        for (int i = 0; i < 13; i++) begin
            int v;
            v = 5 + i;
            if (v > 15) v = 15;
            next_cycle();
            id_x9_x4();
            expect_out("stall_sat", 4'b0000, 1'b1, 32'h210, 4'(v));
        end

        next_cycle();
        id_x9_x4();
        rst_n = 1'b0;
        expect_out("async_reset", 4'b0000, 1'b0, 32'h0, 4'd0);
        next_cycle();
        rst_n = 1'b1;
        expect_out("post_reset", 4'b0000, 1'b0, 32'h0, 4'd0);

        stim_done = 1'b1;
    end

endmodule
